// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and imem.
// The fetch stage is the master; the memory is the slave.
interface fetch_pc_unit_if #(
  parameter int ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack port, presents the
// instruction to decode and steps the PC from the decoder's branch outputs.
module fetch_pc_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [1:0]           BrTaken,
  input  logic                 UncondBr,
  input  logic [ADDR_W-1:0]    BrReg,
  fetch_pc_unit_if.master      imem,
  output logic [31:0]          inst_out,
  output logic                 inst_valid,
  output logic [ADDR_W-1:0]    pc_out,
  output logic [ADDR_W-1:0]    pc_plus4,
  output logic                 illegal_br
);

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  localparam logic [1:0] BR_SEQ = 2'b00;
  localparam logic [1:0] BR_REL = 2'b01;
  localparam logic [1:0] BR_REG = 2'b10;

  logic [1:0]        state;
  logic [ADDR_W-1:0] imm26_se;
  logic [ADDR_W-1:0] imm19_se;
  logic [ADDR_W-1:0] rel_offset;
  logic [ADDR_W-1:0] next_pc;
  logic              consume;

  // Immediates are sign-extended to full width first, so the <<2 cannot lose the sign.
  assign imm26_se   = {{(ADDR_W-26){inst_out[25]}}, inst_out[25:0]};
  assign imm19_se   = {{(ADDR_W-19){inst_out[23]}}, inst_out[23:5]};
  assign rel_offset = (UncondBr ? imm26_se : imm19_se) << 2;

  assign pc_plus4       = pc_out + ADDR_W'(4);
  assign imem.imem_req  = (state == ST_FETCH);
  assign imem.imem_addr = pc_out;

  // Branch inputs only matter on the single cycle the instruction leaves ISSUE.
  assign consume    = (state == ST_ISSUE) && !stall;
  assign illegal_br = consume && (BrTaken == 2'b11);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    next_pc = pc_plus4;
    case (BrTaken)
      BR_SEQ:  next_pc = pc_plus4;
      BR_REL:  next_pc = pc_out + rel_offset;
      BR_REG:  next_pc = BrReg;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state      <= ST_RST;
      pc_out     <= RESET_PC;
      // NOTE: inst_out is a datapath register but has a defined post-reset value of 0.
      inst_out   <= '0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          // One forced idle cycle drops any ack still in flight from before reset.
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            inst_out   <= imem.imem_rdata;
            inst_valid <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            pc_out     <= next_pc;
            inst_valid <= 1'b0;
            state      <= ST_FETCH;
          end
        end
        default: begin
          inst_valid <= 1'b0;
          state      <= ST_RST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, relative/register branches,
// stall hold, wrap-around, reserved branch encoding and reset during a fetch.
module tb_fetch_pc_unit;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic [1:0]    BrTaken;
  logic          UncondBr;
  logic [AW-1:0] BrReg;
  logic [31:0]   inst_out;
  logic          inst_valid;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc_plus4;
  logic          illegal_br;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int valid_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_pc_unit_if #(.ADDR_W(AW)) imem ();

  fetch_pc_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .BrTaken    (BrTaken),
    .UncondBr   (UncondBr),
    .BrReg      (BrReg),
    .imem       (imem.master),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .illegal_br (illegal_br)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Memory answers one cycle after it sees the request.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] word, input string tag);
    for (int i = 0; i < 8 && !imem.imem_req; i++) step();
    check({tag, "_req"}, 64'(imem.imem_req), 64'd1);
    check({tag, "_addr"}, imem.imem_addr, addr);
    check({tag, "_novalid"}, 64'(inst_valid), 64'd0);
    step();
    check({tag, "_addr_hold"}, imem.imem_addr, addr);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = word;
    step();
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = $urandom;
    check({tag, "_valid"}, 64'(inst_valid), 64'd1);
    check({tag, "_req_off"}, 64'(imem.imem_req), 64'd0);
    check({tag, "_inst"}, 64'(inst_out), 64'(word));
    check({tag, "_pc"}, pc_out, addr);
    check({tag, "_pc4"}, pc_plus4, addr + 64'd4);
    valid_cyc.push_back(cyc);
  endtask

  task automatic issue(input logic [1:0] bt, input logic ub, input logic [63:0] tgt,
                       input logic exp_illegal, input string tag);
    BrTaken  = bt;
    UncondBr = ub;
    BrReg    = tgt;
    stall    = 1'b0;
    #1;
    check({tag, "_illegal"}, 64'(illegal_br), 64'(exp_illegal));
    step();
    BrTaken  = 2'($urandom);
    UncondBr = 1'($urandom);
    BrReg    = {$urandom, $urandom};
    check({tag, "_left_issue"}, 64'(inst_valid), 64'd0);
    check({tag, "_illegal_off"}, 64'(illegal_br), 64'd0);
  endtask

  initial begin
    reset           = 1'b0;
    stall           = 1'b0;
    BrTaken         = 2'b00;
    UncondBr        = 1'b0;
    BrReg           = '0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;
    step();
    step();
    check("rst_pc", pc_out, 64'h0);
    check("rst_pc4", pc_plus4, 64'h4);
    check("rst_req", 64'(imem.imem_req), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst_out), 64'd0);
    check("rst_illegal", 64'(illegal_br), 64'd0);
    reset = 1'b1;
    step();

    // Sequential fetch: 0x0, 0x4, 0x8, one instruction every 3 cycles
    do_fetch(64'h0, 32'hD503201F, "seq0");
    issue(2'b00, 1'b0, '0, 1'b0, "seq0");
    do_fetch(64'h4, 32'hD503201F, "seq1");
    issue(2'b00, 1'b0, '0, 1'b0, "seq1");
    do_fetch(64'h8, 32'hD61F0000, "seq2");
    check("valid_period01", 64'(valid_cyc[1] - valid_cyc[0]), 64'd3);
    check("valid_period12", 64'(valid_cyc[2] - valid_cyc[1]), 64'd3);
    issue(2'b10, 1'b0, 64'h40, 1'b0, "br_to40");

    // B with imm26 = -2 from 0x40 -> 0x38
    do_fetch(64'h40, 32'h17FFFFFE, "b_back");
    issue(2'b01, 1'b1, '0, 1'b0, "b_back");
    do_fetch(64'h38, 32'hD61F0000, "at38");
    issue(2'b10, 1'b0, 64'h40, 1'b0, "br_to40b");

    // CBZ with imm19 = 3 from 0x40: taken -> 0x4C, not taken -> 0x44
    do_fetch(64'h40, 32'hB4000060, "cbz_t");
    issue(2'b01, 1'b0, '0, 1'b0, "cbz_t");
    do_fetch(64'h4C, 32'hD61F0000, "at4c");
    issue(2'b10, 1'b0, 64'h40, 1'b0, "br_to40c");
    do_fetch(64'h40, 32'hB4000060, "cbz_nt");
    issue(2'b00, 1'b0, '0, 1'b0, "cbz_nt");
    do_fetch(64'h44, 32'hD61F0000, "at44");
    issue(2'b10, 1'b0, 64'h100, 1'b0, "br_to100");

    // BR from 0x100 to 0x2000
    do_fetch(64'h100, 32'hD61F0020, "br");
    issue(2'b10, 1'b0, 64'h2000, 1'b0, "br");
    do_fetch(64'h2000, 32'h94000004, "bl");

    // Stall 5 cycles with toggling branch inputs and a stray ack
    for (int i = 0; i < 5; i++) begin
      stall           = 1'b1;
      BrTaken         = 2'(i + 1);
      UncondBr        = 1'(i);
      BrReg           = {$urandom, $urandom};
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 32'hDEADBEEF;
      #1;
      check($sformatf("stall%0d_illegal", i), 64'(illegal_br), 64'd0);
      step();
      check($sformatf("stall%0d_valid", i), 64'(inst_valid), 64'd1);
      check($sformatf("stall%0d_req", i), 64'(imem.imem_req), 64'd0);
      check($sformatf("stall%0d_pc", i), pc_out, 64'h2000);
      check($sformatf("stall%0d_pc4", i), pc_plus4, 64'h2004);
      check($sformatf("stall%0d_inst", i), 64'(inst_out), 64'h94000004);
    end
    imem.imem_ack = 1'b0;
    issue(2'b01, 1'b1, 64'h3000, 1'b0, "bl_release");

    // Most negative imm26 from 0x2010 wraps below zero
    do_fetch(64'h2010, 32'h16000000, "b_wrap");
    issue(2'b01, 1'b1, '0, 1'b0, "b_wrap");
    do_fetch(64'hFFFF_FFFF_F800_2010, 32'h00000000, "resv");
    issue(2'b11, 1'b1, 64'h5000, 1'b1, "resv");

    // Reset during FETCH while the ack is late; the ack then arrives stale
    for (int i = 0; i < 8 && !imem.imem_req; i++) step();
    check("late_addr", imem.imem_addr, 64'hFFFF_FFFF_F800_2014);
    reset = 1'b0;
    step();
    check("rst2_pc", pc_out, 64'h0);
    check("rst2_pc4", pc_plus4, 64'h4);
    check("rst2_req", 64'(imem.imem_req), 64'd0);
    check("rst2_valid", 64'(inst_valid), 64'd0);
    check("rst2_inst", 64'(inst_out), 64'd0);
    reset           = 1'b1;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hBAD0BAD0;
    step();
    check("stale_req", 64'(imem.imem_req), 64'd1);
    check("stale_valid", 64'(inst_valid), 64'd0);
    check("stale_inst", 64'(inst_out), 64'd0);
    check("stale_addr", imem.imem_addr, 64'h0);
    imem.imem_ack = 1'b0;
    do_fetch(64'h0, 32'hD503201F, "post_rst");
    issue(2'b00, 1'b0, '0, 1'b0, "post_rst");
    do_fetch(64'h4, 32'hD503201F, "post_rst1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
